// File: rtl/writeback_unit.sv
// Write-back stage: accepts ALU and load results, extends load data, queues results in a
// small FIFO and writes them to the register file one at a time, waiting for an acknowledge
// after each write. Also keeps a per-register pending-write scoreboard for decode.
// Optional forwarding lookup is built when the macro WB_FORWARD_EN is defined.
module writeback_unit #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [2:0]            mem_funct3,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  output logic [31:0]           busy,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic                  rf_write_complete,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWrite, StWait} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, alu_slot;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_ext;
  logic                  push_mem, push_alu, pop, fifo_empty, ack_dec, issue_inc;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic [2:0]            cnt_q [NumRegs];
  logic [2:0]            cnt_d [NumRegs];

  // Load data extension selected by the load type
  always_comb begin
    case (mem_funct3)
      3'b000:  mem_ext = {{(DATA_WIDTH-8){mem_data[7]}}, mem_data[7:0]};
      3'b001:  mem_ext = {{(DATA_WIDTH-16){mem_data[15]}}, mem_data[15:0]};
      3'b010:  mem_ext = {{(DATA_WIDTH-32){mem_data[31]}}, mem_data[31:0]};
      3'b100:  mem_ext = {{(DATA_WIDTH-8){1'b0}}, mem_data[7:0]};
      3'b101:  mem_ext = {{(DATA_WIDTH-16){1'b0}}, mem_data[15:0]};
      3'b110:  mem_ext = {{(DATA_WIDTH-32){1'b0}}, mem_data[31:0]};
      default: mem_ext = mem_data;
    endcase
  end

  // Readies look only at the current occupancy; a pop this cycle does not free a slot yet
  assign fifo_empty = (count_q == '0);
  assign mem_ready  = (count_q != CntW'(FIFO_DEPTH));
  assign alu_ready  = (count_q <= CntW'(FIFO_DEPTH - 2)) || (mem_ready && !mem_valid);

  // rd=0 results are accepted but never stored
  assign push_mem = mem_valid && mem_ready && (mem_rd != '0);
  assign push_alu = alu_valid && alu_ready && (alu_rd != '0);
  assign alu_slot = wr_ptr_q + PtrW'(push_mem);
  assign count_d  = count_q + CntW'(push_mem) + CntW'(push_alu) - CntW'(pop);

  // Queue storage: load entry first, ALU entry behind it
  always_ff @(posedge clk) begin
    if (push_mem) begin
      fifo_addr_q[wr_ptr_q] <= mem_rd;
      fifo_data_q[wr_ptr_q] <= mem_ext;
    end
    if (push_alu) begin
      fifo_addr_q[alu_slot] <= alu_rd;
      fifo_data_q[alu_slot] <= alu_data;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(push_mem) + PtrW'(push_alu);
      rd_ptr_q <= rd_ptr_q + PtrW'(pop);
      count_q  <= count_d;
    end
  end

  // Write FSM state and registered write-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Write FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StWrite;
      StWrite: state_d = StWait;
      StWait:  if (rf_write_complete) state_d = fifo_empty ? StIdle : StWrite;
      default: state_d = StIdle;
    endcase
  end

  // Write FSM outputs: entering WRITE pops the head into the write-port registers
  always_comb begin
    pop       = (state_d == StWrite);
    rf_we_d   = pop;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (pop) begin
      rf_addr_d = fifo_addr_q[rd_ptr_q];
      rf_data_d = fifo_data_q[rd_ptr_q];
    end
  end

  assign rf_write_enable = rf_we_q;
  assign rf_write_addr   = rf_addr_q;
  assign rf_write_data   = rf_data_q;

  // Scoreboard: rf_write_addr still holds the address of the write being acknowledged
  assign ack_dec     = (state_q == StWait) && rf_write_complete;
  assign issue_ready = (cnt_q[issue_rd] != 3'd7);
  assign issue_inc   = issue_valid && issue_ready && (issue_rd != '0);

  // Scoreboard next counts; decrement never wraps below zero
  always_comb begin
    for (int r = 0; r < int'(NumRegs); r++) begin
      logic inc_r, dec_r;
      inc_r    = issue_inc && (issue_rd == ADDR_WIDTH'(r));
      dec_r    = ack_dec && (rf_addr_q == ADDR_WIDTH'(r));
      cnt_d[r] = cnt_q[r];
      if (inc_r && !dec_r) begin
        cnt_d[r] = cnt_q[r] + 3'd1;
      end else if (dec_r && !inc_r && (cnt_q[r] != 3'd0)) begin
        cnt_d[r] = cnt_q[r] - 3'd1;
      end
    end
  end

  // Scoreboard counters
  always_ff @(posedge clk) begin
    for (int r = 0; r < int'(NumRegs); r++) begin
      if (reset) cnt_q[r] <= 3'd0;
      else       cnt_q[r] <= cnt_d[r];
    end
  end

  // Busy vector; x0 never reports a pending write
  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) begin
      if (r < int'(NumRegs)) busy[r] = (cnt_q[r] != 3'd0);
    end
  end

`ifdef WB_FORWARD_EN
  // Forwarding: in-flight write is oldest, later FIFO entries override it
  always_comb begin
    logic [PtrW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      if ((state_q != StIdle) && (rf_addr_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_data_q;
      end
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        idx = rd_ptr_q + PtrW'(i);
        if ((CntW'(i) < count_q) && (fifo_addr_q[idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = fifo_data_q[idx];
        end
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^fwd_addr;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: vector table for load extension, hand sequences for
// multi-cycle corners, and randomized traffic checked against a queue-based reference model.
module tb_writeback_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, issue_valid, issue_ready;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rf_write_addr, fwd_addr;
  logic [63:0] alu_data, mem_data, rf_write_data, fwd_data;
  logic [2:0]  mem_funct3;
  logic [31:0] busy;
  logic        rf_write_enable, rf_write_complete, fwd_hit;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk              (clk),
    .reset            (reset),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_rd           (mem_rd),
    .mem_data         (mem_data),
    .mem_funct3       (mem_funct3),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .issue_ready      (issue_ready),
    .busy             (busy),
    .rf_write_enable  (rf_write_enable),
    .rf_write_addr    (rf_write_addr),
    .rf_write_data    (rf_write_data),
    .rf_write_complete(rf_write_complete),
    .fwd_addr         (fwd_addr),
    .fwd_hit          (fwd_hit),
    .fwd_data         (fwd_data)
  );

  typedef struct { logic [4:0] addr; logic [63:0] data; } ent_t;
  typedef struct { logic [2:0] f3; logic [63:0] d; logic [63:0] exp; } vec_t;

  // Reference model: results accepted but not yet seen on the write port, pending counts
  ent_t        exp_q[$];
  int          cnt_m[32];
  int          outstanding;
  logic [4:0]  last_addr;
  logic [63:0] last_data;
  bit          ack_en, spur;
  int          n_cmp, n_fail, cyc, n_writes, n_acks, last_wr_cyc;
  logic [4:0]  last_wr_addr;
  logic [63:0] last_wr_data;

  function automatic logic [63:0] ext_model(input logic [2:0] f, input logic [63:0] d);
    byte     sb;
    shortint sh;
    int      sw;
    sb = d[7:0];
    sh = d[15:0];
    sw = d[31:0];
    case (f)
      3'd0:    return longint'(sb);
      3'd1:    return longint'(sh);
      3'd2:    return longint'(sw);
      3'd4:    return {56'd0, d[7:0]};
      3'd5:    return {48'd0, d[15:0]};
      3'd6:    return {32'd0, d[31:0]};
      default: return d;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  // One clock: check combinational outputs, update model, advance, check write port
  task automatic tick();
    int          free;
    bit          ar, mr, ir, inc, dec, fh;
    logic [31:0] bexp;
    logic [63:0] fd;
    ent_t        e;
    #1;
    free = DEPTH - exp_q.size();
    mr   = (free >= 1);
    ar   = (free >= 2) || ((free >= 1) && !mem_valid);
    ir   = (cnt_m[issue_rd] != 7);
    check("mem_ready", mem_ready, mr);
    check("alu_ready", alu_ready, ar);
    check("issue_ready", issue_ready, ir);
    bexp = '0;
    for (int r = 1; r < 32; r++) bexp[r] = (cnt_m[r] != 0);
    check("busy", busy, bexp);
    fh = 1'b0;
    fd = '0;
`ifdef WB_FORWARD_EN
    if (fwd_addr != 0) begin
      if (outstanding > 0 && last_addr == fwd_addr) begin
        fh = 1'b1;
        fd = last_data;
      end
      foreach (exp_q[i]) begin
        if (exp_q[i].addr == fwd_addr) begin
          fh = 1'b1;
          fd = exp_q[i].data;
        end
      end
    end
`endif
    check("fwd_hit", fwd_hit, fh);
    check("fwd_data", fwd_data, fd);
    if (mem_valid && mr && mem_rd != 0) exp_q.push_back('{mem_rd, ext_model(mem_funct3, mem_data)});
    if (alu_valid && ar && alu_rd != 0) exp_q.push_back('{alu_rd, alu_data});
    inc = issue_valid && ir && (issue_rd != 0);
    dec = rf_write_complete && (outstanding > 0) && !rf_write_enable;
    if (dec) begin
      outstanding--;
      n_acks++;
    end
    if (!(inc && dec && issue_rd == last_addr)) begin
      if (inc) cnt_m[issue_rd]++;
      if (dec && cnt_m[last_addr] > 0) cnt_m[last_addr]--;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rf_write_enable) begin
      n_writes++;
      last_wr_cyc  = cyc;
      last_wr_addr = rf_write_addr;
      last_wr_data = rf_write_data;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write (cycle %0d)",
                 rf_write_addr, rf_write_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", rf_write_addr, e.addr);
        check("wr_data", rf_write_data, e.data);
        last_addr = e.addr;
        last_data = e.data;
        outstanding++;
      end
    end
    // Acknowledge one cycle after a write; spurious pulses only where the DUT must ignore them
    rf_write_complete = rf_write_enable ? spur : ((outstanding > 0) ? ack_en : spur);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    rf_write_complete = 1'b0;
    spur = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    outstanding = 0;
  endtask

  task automatic wait_writes(input int target, input string nm);
    for (int k = 0; k < 60 && n_writes < target; k++) tick();
    check(nm, n_writes, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   n0, a0, c1;
    n_cmp = 0; n_fail = 0; cyc = 0; n_writes = 0; n_acks = 0;
    alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0; mem_funct3 = 0;
    issue_rd = 0; fwd_addr = 0; ack_en = 1'b1; last_addr = 0; last_data = 0;
    do_reset();
    check("rst_we", rf_write_enable, 0);
    check("rst_addr", rf_write_addr, 0);
    check("rst_data", rf_write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    check("rst_fwd_data", fwd_data, 0);
    tick();

    // Load extension table
    vecs[0] = '{3'b000, 64'h80, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{3'b100, 64'h80, 64'h80};
    vecs[2] = '{3'b001, 64'h8001, 64'hFFFF_FFFF_FFFF_8001};
    vecs[3] = '{3'b101, 64'hAAAA_0000_1234_8001, 64'h8001};
    vecs[4] = '{3'b010, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_8000_0000};
    vecs[5] = '{3'b110, 64'h1234_5678_8000_0000, 64'h8000_0000};
    vecs[6] = '{3'b011, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    vecs[7] = '{3'b111, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    vecs[8] = '{3'b000, 64'h1234_5678_9ABC_DE7F, 64'h7F};
    vecs[9] = '{3'b010, 64'hFFFF_FFFF_7FFF_FFFF, 64'h7FFF_FFFF};
    foreach (vecs[i]) begin
      n0 = n_writes;
      mem_valid = 1'b1; mem_rd = 5; mem_funct3 = vecs[i].f3; mem_data = vecs[i].d;
      tick();
      idle();
      tick();
      check("ld_latency", n_writes - n0, 1);
      check("ld_addr", last_wr_addr, 5);
      check("ld_data", last_wr_data, vecs[i].exp);
      repeat (2) tick();
    end

    // Same-cycle ALU and load: load written first, ALU two cycles later
    alu_valid = 1'b1; alu_rd = 3; alu_data = 64'h11;
    mem_valid = 1'b1; mem_rd = 4; mem_funct3 = 3'b011; mem_data = 64'h22;
    tick();
    idle();
    tick();
    check("pair_first_addr", last_wr_addr, 4);
    check("pair_first_data", last_wr_data, 64'h22);
    c1 = last_wr_cyc;
    repeat (2) tick();
    check("pair_second_addr", last_wr_addr, 3);
    check("pair_gap", last_wr_cyc - c1, 2);
    repeat (2) tick();

    // Fill the FIFO with acknowledges held off
    ack_en = 1'b0;
    n0 = n_writes;
    for (int k = 0; k < 5; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + k); alu_data = 64'h100 + 64'(k);
      tick();
    end
    alu_rd = 20; alu_data = 64'hBAD; mem_valid = 1'b1; mem_rd = 21; mem_data = 64'hBAD;
    #1;
    check("full_alu_ready", alu_ready, 0);
    check("full_mem_ready", mem_ready, 0);
    repeat (3) tick();
    idle();
    ack_en = 1'b1;
    wait_writes(n0 + 5, "fill_writes");
    repeat (2) tick();
    #1;
    check("drain_alu_ready", alu_ready, 1);
    check("drain_mem_ready", mem_ready, 1);

    // Scoreboard counting
    issue_valid = 1'b1; issue_rd = 7;
    repeat (2) tick();
    idle();
    check("busy7_issued", busy[7], 1);
    a0 = n_acks;
    alu_valid = 1'b1; alu_rd = 7; alu_data = 64'h1;
    tick();
    alu_data = 64'h2;
    tick();
    idle();
    for (int k = 0; k < 20 && n_acks < a0 + 1; k++) tick();
    check("busy7_after_first", busy[7], 1);
    for (int k = 0; k < 20 && n_acks < a0 + 2; k++) tick();
    check("busy7_after_second", busy[7], 0);
    issue_valid = 1'b1; issue_rd = 0;
    tick();
    idle();
    check("busy_rd0", busy, 0);
    issue_valid = 1'b1; issue_rd = 9;
    repeat (8) tick();
    check("issue_ready_sat", issue_ready, 0);
    check("busy9_sat", busy[9], 1);
    idle();

    // rd=0 is accepted and dropped
    do_reset();
    n0 = n_writes;
    alu_valid = 1'b1; alu_rd = 0; alu_data = 64'hDEAD;
    #1;
    check("rd0_alu_ready", alu_ready, 1);
    tick();
    idle();
    repeat (4) tick();
    check("rd0_no_write", n_writes - n0, 0);

    // Reset with queued entries and pending counts
    ack_en = 1'b0;
    issue_valid = 1'b1; issue_rd = 12;
    tick();
    issue_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(12 + k); alu_data = 64'h200 + 64'(k);
      tick();
    end
    idle();
    tick();
    do_reset();
    ack_en = 1'b1;
    n0 = n_writes;
    repeat (10) tick();
    check("reset_no_write", n_writes - n0, 0);
    check("reset_busy", busy, 0);

    // Forwarding of the youngest pending write
    ack_en = 1'b0;
    alu_valid = 1'b1; alu_rd = 1; alu_data = 64'hAA;
    tick();
    alu_rd = 9; alu_data = 64'h1;
    tick();
    alu_data = 64'h2;
    tick();
    idle();
    fwd_addr = 9;
    #1;
`ifdef WB_FORWARD_EN
    check("fwd9_hit", fwd_hit, 1);
    check("fwd9_data", fwd_data, 64'h2);
`else
    check("fwd9_hit", fwd_hit, 0);
    check("fwd9_data", fwd_data, 0);
`endif
    fwd_addr = 0;
    #1;
    check("fwd0_hit", fwd_hit, 0);
    tick();
    ack_en = 1'b1;
    repeat (12) tick();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      alu_valid   = ($urandom % 3) != 0;
      alu_rd      = 5'($urandom % 8);
      alu_data    = {$urandom, $urandom};
      mem_valid   = ($urandom % 3) != 0;
      mem_rd      = 5'($urandom % 8);
      mem_data    = {$urandom, $urandom};
      mem_funct3  = 3'($urandom);
      issue_valid = ($urandom % 4) == 0;
      issue_rd    = 5'($urandom % 8);
      ack_en      = ($urandom % 8) != 0;
      spur        = ($urandom % 4) == 0;
      fwd_addr    = 5'($urandom % 8);
      tick();
    end
    idle();
    ack_en = 1'b1;
    spur = 1'b0;
    for (int k = 0; k < 100 && (exp_q.size() != 0 || outstanding != 0); k++) tick();
    check("random_drained", exp_q.size() + outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
